imem_load_ctrl: RTL

//  Sequences the 64x32 instruction memory between a program loader (valid/ready word stream) and CPU fetch.

---
 rtl/imem_load_ctrl_if.sv | 31 +++
 rtl/imem_load_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/imem_load_ctrl_if.sv
// Loader word stream plus instruction-memory write/read port shared by the
// load controller (slave) and the loader/memory side (master).
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output ld_valid,
        output ld_data,
        input  ld_ready,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        output ld_ready,
        output mem_addr,
        output mem_we,
        output mem_wdata
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory load sequencer: stalls the CPU while a program is streamed
// into words 0..len-1, then pulses a PC clear and lets the CPU run.
// Optional running XOR checksum of loaded words: define IMEM_CHECKSUM_EN.
module imem_load_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [ADDR_W-1:0] cpu_pc_word,
    imem_load_ctrl_if.slave   bus,
    output logic              cpu_stall,
    output logic              cpu_pc_clr,
    output logic              load_done,
    output logic [1:0]        state,
    output logic [DATA_W-1:0] checksum
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int            DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LEN = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_LEN   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W:0]   remaining_reg;
    logic [ADDR_W:0]   len_clamped;
    logic              start_accept;
    logic              xfer;

    // Lengths beyond the memory depth are silently clamped so wr_ptr never wraps.
    assign len_clamped  = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
    assign start_accept = load_start && ((state_reg == ST_IDLE) || (state_reg == ST_RUN));
    assign xfer         = bus.ld_valid && bus.ld_ready;

    assign bus.ld_ready  = (state_reg == ST_LOAD);
    assign bus.mem_we    = xfer;
    assign bus.mem_wdata = bus.ld_data;
    assign bus.mem_addr  = (state_reg == ST_LOAD) ? wr_ptr_reg : cpu_pc_word;
    assign cpu_stall     = (state_reg != ST_RUN);
    assign cpu_pc_clr    = (state_reg == ST_FLUSH);
    assign load_done     = (state_reg == ST_FLUSH);
    assign state         = state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            remaining_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_RUN: begin
                    if (start_accept) begin
                        wr_ptr_reg    <= '0;
                        remaining_reg <= len_clamped;
                        state_reg     <= (len_clamped != '0) ? ST_LOAD : ST_FLUSH;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                        remaining_reg <= remaining_reg - ONE_LEN;
                        if (remaining_reg == ONE_LEN) begin
                            state_reg <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: state_reg <= ST_RUN;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else if (start_accept) begin
            checksum_reg <= '0;
        end else if (xfer) begin
            checksum_reg <= checksum_reg ^ bus.ld_data;
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule
